mult_escalar_matriz_param: RTL and testbench

MULT_ESCALAR_MATRIZ_PARAM -- requirements
Module: mult_escalar_matriz_param

---
 rtl/mult_escalar_matriz_param_if.sv | 31 +++
 rtl/mult_escalar_matriz_param.sv | 116 +++++++++++
 tb/tb_mult_escalar_matriz_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_escalar_matriz_param_if.sv
// Handshake and data bundle for the scalar-by-matrix multiplier.
// Producer side (master) offers a matrix and scalar; consumer side takes the result.
// Both directions use valid/ready; data is held stable while valid is high and ready is low.
interface mult_escalar_matriz_param_if #(
  parameter int DIM = 5,
  parameter int W   = 8
);
  localparam int N = DIM * DIM;

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] matriz_in;
  logic [W-1:0]   escalar;
  logic           sat_en;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] matriz_out;
  logic           overflow;

  // Requester / testbench side
  modport master (
    output in_valid, matriz_in, escalar, sat_en, out_ready,
    input  in_ready, out_valid, matriz_out, overflow
  );

  // Multiplier side
  modport slave (
    input  in_valid, matriz_in, escalar, sat_en, out_ready,
    output in_ready, out_valid, matriz_out, overflow
  );
endinterface

// File: rtl/mult_escalar_matriz_param.sv
// Multiplies a DIM x DIM signed matrix by a signed scalar, LANES elements per cycle, wrap or saturate.
// Latency: result valid N/LANES cycles after the acceptance edge.
// Backpressure: accepts only in IDLE; holds result and overflow in DONE until out_ready.
module mult_escalar_matriz_param #(
  parameter int DIM   = 5,
  parameter int W     = 8,
  parameter int LANES = 5
) (
  input logic clk,
  input logic rst,
  mult_escalar_matriz_param_if.slave bus
);

  localparam int N      = DIM * DIM;
  localparam int NG     = N / LANES;
  localparam int GW     = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);
  localparam logic [W-1:0]  SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SMIN   = {1'b1, {(W-1){1'b0}}};

  if ((N % LANES) != 0) begin : g_lanes_check
    $error("mult_escalar_matriz_param: DIM*DIM must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         g;
  logic [N*W-1:0]        mat_reg;
  logic signed [W-1:0]   esc_reg;
  logic                  sat_reg;
  logic [N*W-1:0]        res_reg;
  logic                  ovf_reg;

  logic [LANES-1:0][W-1:0] lane_res;
  logic [LANES-1:0]        lane_ovf;

  // One multiplier per lane, working on the element group selected by g
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W-1:0]   a;
    logic signed [2*W-1:0] p;
    logic                  oor;

    // Full-precision product, range check, then wrap or clamp
    always_comb begin
      a   = mat_reg[(int'(g) * LANES + l) * W +: W];
      p   = a * esc_reg;
      // In range iff the top W+1 bits are all equal (pure sign extension)
      oor = (|p[2*W-1:W-1]) & ~(&p[2*W-1:W-1]);
      lane_ovf[l] = oor;
      if (oor && sat_reg)
        lane_res[l] = p[2*W-1] ? SMIN : SMAX;
      else
        lane_res[l] = p[W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; in_valid only matters in IDLE, out_ready only in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = CALC;
      CALC:    if (g == G_LAST)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at acceptance, group-by-group result write in CALC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g       <= '0;
      mat_reg <= '0;
      esc_reg <= '0;
      sat_reg <= 1'b0;
      res_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mat_reg <= bus.matriz_in;
            esc_reg <= bus.escalar;
            sat_reg <= bus.sat_en;
            res_reg <= '0;
            ovf_reg <= 1'b0;
            g       <= '0;
          end
        end
        CALC: begin
          for (int l = 0; l < LANES; l++) begin
            res_reg[(int'(g) * LANES + l) * W +: W] <= lane_res[l];
          end
          ovf_reg <= ovf_reg | (|lane_ovf);
          g       <= (g == G_LAST) ? '0 : g + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: handshake flags decoded from state, data straight from registers
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == DONE);
    bus.matriz_out = res_reg;
    bus.overflow   = ovf_reg;
  end

endmodule

// File: tb/tb_mult_escalar_matriz_param.sv
// Directed bench for mult_escalar_matriz_param: a 5-lane instance and a 1-lane instance
// run the same vector table side by side; hand sequences cover hold-in-DONE,
// input isolation during CALC, and asynchronous reset mid-operation.
module tb_mult_escalar_matriz_param;

  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int N   = DIM * DIM;
  localparam int BW  = N * W;

  typedef struct {
    logic [BW-1:0] mat;
    logic [W-1:0]  esc;
    logic          sat;
    logic [BW-1:0] exp;
    logic          exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  mult_escalar_matriz_param_if #(.DIM(DIM), .W(W)) ia ();
  mult_escalar_matriz_param_if #(.DIM(DIM), .W(W)) ib ();

  mult_escalar_matriz_param #(.DIM(DIM), .W(W), .LANES(5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  mult_escalar_matriz_param #(.DIM(DIM), .W(W), .LANES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] splat(input logic [W-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  // Offer one operation to both instances, then time and capture each result
  task automatic apply_vec(input vec_t v, input string tag);
    int            lat_a, lat_b;
    logic [BW-1:0] res_a, res_b;
    logic          ovf_a, ovf_b;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rdy_a"}, BW'(ia.in_ready), BW'(1'b1));
    chk({tag, "_rdy_b"}, BW'(ib.in_ready), BW'(1'b1));
    ia.in_valid = 1'b1; ia.matriz_in = v.mat; ia.escalar = v.esc; ia.sat_en = v.sat;
    ib.in_valid = 1'b1; ib.matriz_in = v.mat; ib.escalar = v.esc; ib.sat_en = v.sat;
    @(posedge clk);
    #1;
    // Disturb the inputs right after acceptance; the result must not notice
    ia.in_valid = 1'b0; ia.matriz_in = ~v.mat; ia.escalar = ~v.esc; ia.sat_en = ~v.sat;
    ib.in_valid = 1'b0; ib.matriz_in = ~v.mat; ib.escalar = ~v.esc; ib.sat_en = ~v.sat;
    lat_a = -1; lat_b = -1;
    res_a = '0; res_b = '0; ovf_a = 1'b0; ovf_b = 1'b0;
    for (int c = 1; c <= 40 && (lat_a < 0 || lat_b < 0); c++) begin
      @(posedge clk);
      #1;
      if (lat_a < 0 && ia.out_valid) begin lat_a = c; res_a = ia.matriz_out; ovf_a = ia.overflow; end
      if (lat_b < 0 && ib.out_valid) begin lat_b = c; res_b = ib.matriz_out; ovf_b = ib.overflow; end
    end
    chk({tag, "_lat_a"}, BW'(lat_a), BW'(5));
    chk({tag, "_lat_b"}, BW'(lat_b), BW'(25));
    chk({tag, "_res_a"}, res_a, v.exp);
    chk({tag, "_res_b"}, res_b, v.exp);
    chk({tag, "_ovf_a"}, BW'(ovf_a), BW'(v.exp_ovf));
    chk({tag, "_ovf_b"}, BW'(ovf_b), BW'(v.exp_ovf));
  endtask

  vec_t          vt[10];
  vec_t          vr;
  logic [BW-1:0] m, e;
  int            lat;
  logic          ok;

  initial begin
    nvec = 0;
    nerr = 0;

    // Vector table
    vt[0] = '{splat(8'd3), 8'd4, 1'b0, splat(8'd12), 1'b0};
    m = splat(8'd1); m[7:0] = 8'd100;
    e = splat(8'd2); e[7:0] = 8'hC8;
    vt[1] = '{m, 8'd2, 1'b0, e, 1'b1};
    e[7:0] = 8'h7F;
    vt[2] = '{m, 8'd2, 1'b1, e, 1'b1};
    m = '0; m[7:0] = 8'h80;
    e = '0; e[7:0] = 8'h80;
    vt[3] = '{m, 8'hFF, 1'b0, e, 1'b1};
    e[7:0] = 8'h7F;
    vt[4] = '{m, 8'hFF, 1'b1, e, 1'b1};
    e[7:0] = 8'h80;
    vt[5] = '{m, 8'h01, 1'b1, e, 1'b0};
    for (int i = 0; i < N; i++) begin
      m[i*W +: W] = W'(i - 12);
      e[i*W +: W] = W'((i - 12) * -10);
    end
    vt[6] = '{m, 8'hF6, 1'b1, e, 1'b0};
    m = splat(8'hC0); m[7:0] = 8'd127;
    e = splat(8'h7F); e[7:0] = 8'h80;
    vt[7] = '{m, 8'hFE, 1'b1, e, 1'b1};
    e = splat(8'h80); e[7:0] = 8'h02;
    vt[8] = '{m, 8'hFE, 1'b0, e, 1'b1};
    m = '0; m[BW-1 -: W] = 8'd64;
    e = '0; e[BW-1 -: W] = 8'h80;
    vt[9] = '{m, 8'd2, 1'b0, e, 1'b1};

    // Reset state
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.matriz_in = '0; ia.escalar = '0; ia.sat_en = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.matriz_in = '0; ib.escalar = '0; ib.sat_en = 1'b0; ib.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld_a", BW'(ia.out_valid), '0);
    chk("rst_rdy_a", BW'(ia.in_ready), BW'(1'b1));
    chk("rst_dat_a", ia.matriz_out, '0);
    chk("rst_ovf_a", BW'(ia.overflow), '0);
    chk("rst_vld_b", BW'(ib.out_valid), '0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      apply_vec(vt[k], $sformatf("v%0d", k));
    end

    // Hold in DONE while the producer misbehaves; inputs also change during CALC
    ia.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 1'b1; ia.matriz_in = splat(8'd3); ia.escalar = 8'd4; ia.sat_en = 1'b0;
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0; ia.matriz_in = splat(8'h7F); ia.escalar = 8'h7F; ia.sat_en = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (ia.out_valid) lat = c;
    end
    chk("hold_lat", BW'(lat), BW'(5));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ia.in_valid  = k[0];
      ia.matriz_in = ~ia.matriz_in;
      ia.escalar   = W'($urandom);
      ia.sat_en    = ~ia.sat_en;
      @(posedge clk);
      #1;
      chk($sformatf("hold_vld%0d", k), BW'(ia.out_valid), BW'(1'b1));
      chk($sformatf("hold_dat%0d", k), ia.matriz_out, splat(8'd12));
      chk($sformatf("hold_ovf%0d", k), BW'(ia.overflow), '0);
      chk($sformatf("hold_rdy%0d", k), BW'(ia.in_ready), '0);
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_vld", BW'(ia.out_valid), '0);
    chk("release_rdy", BW'(ia.in_ready), BW'(1'b1));

    // Asynchronous reset two cycles into CALC
    @(negedge clk);
    ia.in_valid = 1'b1; ia.matriz_in = splat(8'd7); ia.escalar = 8'd2; ia.sat_en = 1'b0;
    @(posedge clk);
    #1;
    ia.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_part", BW'(ia.matriz_out[7:0]), BW'(8'd14));
    chk("pre_rst_vld", BW'(ia.out_valid), '0);
    rst = 1'b1;
    #1;
    chk("arst_dat", ia.matriz_out, '0);
    chk("arst_vld", BW'(ia.out_valid), '0);
    chk("arst_ovf", BW'(ia.overflow), '0);
    chk("arst_rdy", BW'(ia.in_ready), BW'(1'b1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) ok = 1'b0;
    end
    chk("post_rst_idle", BW'(ok), BW'(1'b1));
    vr = '{splat(8'd5), 8'hFD, 1'b0, splat(8'hF1), 1'b0};
    apply_vec(vr, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
